// File: rtl/seg_display_mux_if.sv
// BCD value bus between the UART BCD conversion stage (master) and the display mux (slave).
interface seg_display_mux_if;
  logic [11:0] bcd_in;
  logic        bcd_valid;

  modport master (output bcd_in, output bcd_valid);
  modport slave  (input  bcd_in, input  bcd_valid);
endinterface

// File: rtl/seg_display_mux.sv
// 3-digit time-multiplexed seven-segment driver; new values are committed only at frame wrap.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (hundreds, tens).
module seg_display_mux #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seg_display_mux_if.slave   bcd_bus,
  output logic [7:0]         seg_out,
  output logic [2:0]         dig_sel,
  output logic               frame_done
);

  localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [7:0]       SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0]       DIG_OFF   = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } slot_state_t;

  localparam slot_state_t RESET_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("seg_display_mux: REFRESH_DIV must be at least 2");
  end
  if ((BLANK_CYCLES < 0) || (BLANK_CYCLES >= REFRESH_DIV)) begin : g_bad_blank_cycles
    $error("seg_display_mux: BLANK_CYCLES must be in 0..REFRESH_DIV-1");
  end

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       digit_idx;
  logic [1:0]       idx_next;
  slot_state_t      state;
  slot_state_t      state_next;
  logic             slot_wrap;
  logic             frame_wrap;
  logic [11:0]      shadow;
  logic [11:0]      active;
  logic             pending;
  logic [3:0]       nibble;
  logic [2:0]       dig_onehot;
  logic [7:0]       pattern;
  logic [7:0]       seg_raw;
  logic [2:0]       dig_raw;

  function automatic logic [7:0] encode_digit(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = 8'h40;
    endcase
    return seg;
  endfunction

  // Slot timing; the state register always describes the slot phase of the current counter value.
  always_comb begin
    slot_wrap  = (slot_cnt == CNT_LAST);
    frame_wrap = slot_wrap && (digit_idx == 2'd2);
    cnt_next   = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
    if (!slot_wrap) begin
      idx_next = digit_idx;
    end else if (digit_idx == 2'd2) begin
      idx_next = 2'd0;
    end else begin
      idx_next = digit_idx + 2'd1;
    end
    state_next = ((BLANK_CYCLES > 0) && (cnt_next < BLANK_END)) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    nibble     = 4'h0;
    dig_onehot = 3'b000;
    case (digit_idx)
      2'd0: begin
        nibble     = active[3:0];
        dig_onehot = 3'b001;
      end
      2'd1: begin
        nibble     = active[7:4];
        dig_onehot = 3'b010;
      end
      2'd2: begin
        nibble     = active[11:8];
        dig_onehot = 3'b100;
      end
      default: begin
        nibble     = 4'h0;
        dig_onehot = 3'b000;
      end
    endcase
    pattern = encode_digit(nibble);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Only exact zero nibbles blank; A-F still show the dash. The digit enable stays on.
    if ((digit_idx == 2'd2) && (active[11:8] == 4'h0)) begin
      pattern = 8'h00;
    end
    if ((digit_idx == 2'd1) && (active[11:8] == 4'h0) && (active[7:4] == 4'h0)) begin
      pattern = 8'h00;
    end
`endif
    seg_raw = (state == ST_SHOW) ? pattern    : 8'h00;
    dig_raw = (state == ST_SHOW) ? dig_onehot : 3'b000;
  end

  // Scan FSM, registered outputs and the shadow/active commit path; a strobe on the wrap cycle bypasses the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt   <= '0;
      digit_idx  <= 2'd0;
      state      <= RESET_STATE;
      shadow     <= 12'h000;
      active     <= 12'h000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg_out    <= SEG_OFF;
      dig_sel    <= DIG_OFF;
    end else begin
      slot_cnt   <= cnt_next;
      digit_idx  <= idx_next;
      state      <= state_next;
      frame_done <= frame_wrap;
      seg_out    <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      dig_sel    <= DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;

      if (bcd_bus.bcd_valid) begin
        shadow  <= bcd_bus.bcd_in;
        pending <= 1'b1;
      end

      if (frame_wrap) begin
        if (bcd_bus.bcd_valid) begin
          active  <= bcd_bus.bcd_in;
          pending <= 1'b0;
        end else if (pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux: scoreboard of committed values, checked cycle by cycle per frame.
module tb_seg_display_mux;

  localparam int REFRESH_DIV  = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 3 * REFRESH_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg_out;
  logic [2:0] dig_sel;
  logic       frame_done;

  seg_display_mux_if bcd_bus();

  seg_display_mux #(
    .REFRESH_DIV   (REFRESH_DIV),
    .BLANK_CYCLES  (BLANK_CYCLES),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bcd_bus   (bcd_bus),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] sb_q[$];
  logic [11:0] cur_exp;
  bit          queued_this_frame;

  // Active-high segment patterns indexed by nibble; A-F are the dash.
  logic [7:0] seg_table [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                   8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] exp_pattern(input logic [11:0] value, input int idx);
    logic [3:0] nib;
    logic [7:0] pat;
    nib = value[idx*4 +: 4];
    pat = seg_table[nib];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if ((idx == 2) && (value[11:8] == 4'h0)) pat = 8'h00;
    if ((idx == 1) && (value[11:8] == 4'h0) && (value[7:4] == 4'h0)) pat = 8'h00;
`endif
    return pat;
  endfunction

  // Drives a one-cycle strobe; a second strobe in the same frame replaces the queued value.
  task automatic applyStimulus(input logic [11:0] value);
    bcd_bus.bcd_in    = value;
    bcd_bus.bcd_valid = 1'b1;
    if (queued_this_frame) begin
      void'(sb_q.pop_back());
    end
    sb_q.push_back(value);
    queued_this_frame = 1'b1;
  endtask

  task automatic check_sample(input int k);
    int         pos;
    int         idx;
    int         cnt;
    logic [7:0] es;
    logic [2:0] ed;
    logic [2:0] onehot;
    pos = k - 1;
    idx = pos / REFRESH_DIV;
    cnt = pos % REFRESH_DIV;
    if (cnt < BLANK_CYCLES) begin
      es = 8'hFF;
      ed = 3'b111;
    end else begin
      onehot = 3'b001 << idx;
      ed     = ~onehot;
      es     = ~exp_pattern(cur_exp, idx);
    end
    checkOutput($sformatf("seg_out val=%h k=%0d", cur_exp, k), {4'h0, seg_out}, {4'h0, es});
    checkOutput($sformatf("dig_sel val=%h k=%0d", cur_exp, k), {9'h000, dig_sel}, {9'h000, ed});
    checkOutput($sformatf("frame_done k=%0d", k), {11'h000, frame_done}, {11'h000, (k == FRAME)});
  endtask

  // One full frame starting right after a frame boundary; optional strobes at samples ka and kb.
  task automatic run_frame(input int ka, input logic [11:0] va, input int kb, input logic [11:0] vb);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      check_sample(k);
      bcd_bus.bcd_valid = 1'b0;
      if (k == ka) applyStimulus(va);
      else if (k == kb) applyStimulus(vb);
    end
    if (sb_q.size() > 0) cur_exp = sb_q.pop_front();
    queued_this_frame = 1'b0;
  endtask

  task automatic reset_mid_frame();
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check_sample(k);
      bcd_bus.bcd_valid = 1'b0;
      if (k == 5) applyStimulus(12'h321);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset seg_out", {4'h0, seg_out}, 12'h0FF);
    checkOutput("mid_reset dig_sel", {9'h000, dig_sel}, 12'h007);
    checkOutput("mid_reset frame_done", {11'h000, frame_done}, 12'h000);
    reset = 1'b0;
    sb_q.delete();
    cur_exp           = 12'h000;
    queued_this_frame = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bcd_bus.bcd_in    = 12'h888;
    bcd_bus.bcd_valid = 1'b1;
    cur_exp           = 12'h000;
    queued_this_frame = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset seg_out c=%0d", i), {4'h0, seg_out}, 12'h0FF);
      checkOutput($sformatf("reset dig_sel c=%0d", i), {9'h000, dig_sel}, 12'h007);
      checkOutput($sformatf("reset frame_done c=%0d", i), {11'h000, frame_done}, 12'h000);
    end
    reset             = 1'b0;
    bcd_bus.bcd_valid = 1'b0;
    bcd_bus.bcd_in    = 12'h000;

    run_frame(0, 12'h000, 0, 12'h000);
    run_frame(10, 12'h255, 0, 12'h000);
    run_frame(4, 12'h123, 15, 12'h045);
    run_frame(23, 12'h007, 0, 12'h000);
    run_frame(5, 12'h0A5, 0, 12'h000);
    run_frame(7, 12'h005, 0, 12'h000);
    reset_mid_frame();
    run_frame(0, 12'h000, 0, 12'h000);
    run_frame(0, 12'h000, 0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Consumes the 12-bit, 3-digit BCD word and its one-cycle done strobe from the UART BCD conversion stage.
- Drives a time-multiplexed 3-digit common-anode/cathode seven-segment display.
- Latches each new value into a shadow register and commits it only at a frame boundary, so a digit is never torn mid-scan.
- Provides a blanking gap between digit slots to suppress ghosting.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; legal range ≥2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; legal range 0..REFRESH_DIV-1.
- SEG_ACTIVE_LOW, 1, 1 inverts seg_out (segment on = 0).
- DIG_ACTIVE_LOW, 1, 1 inverts dig_sel (digit enabled = 0).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- bcd_in  in  12  [11:8] hundreds, [7:4] tens, [3:0] ones.
- bcd_valid  in  1  one-cycle strobe; bcd_in is sampled on this cycle.
- seg_out  out  8  {dp,g,f,e,d,c,b,a}; registered.
- dig_sel  out  3  [0] ones (rightmost), [1] tens, [2] hundreds; one-hot active; registered.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset:
  - Slot counter = 0, digit index = 0, shadow = 0, active = 0, pending = 0, frame_done = 0.
  - seg_out = all segments off (8'hFF if SEG_ACTIVE_LOW, else 8'h00).
  - dig_sel = all digits off (3'b111 if DIG_ACTIVE_LOW, else 3'b000).
  - Reset asserted mid-frame aborts the scan immediately; the next cycle shows the reset values.
- Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index advances 0→1→2→0.
- Two-state FSM per slot:
  - BLANK while counter < BLANK_CYCLES: all digits and segments off.
  - SHOW otherwise: the selected digit is enabled and its pattern is driven.
  - With BLANK_CYCLES = 0, BLANK never occurs.
- Outputs are registered: seg_out/dig_sel reflect the counter/index state with 1 cycle of latency.
- Segment encoding before polarity (active-high, hex):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Any nibble A–F shows a dash, 40.
  - dp is always off.
- Capture:
  - bcd_valid=1 → shadow ← bcd_in, pending ← 1.
  - A later strobe before commit overwrites shadow; last value wins.
- Commit: on the cycle where the digit index wraps 2→0:
  - If bcd_valid is high that same cycle: active ← bcd_in (bypass) and pending ← 0.
  - Else if pending: active ← shadow and pending ← 0.
  - frame_done pulses for 1 cycle on this wrap whether or not a commit occurs.
- Worst-case latency from bcd_valid to visible on the display: 3·REFRESH_DIV + 1 cycles.
- Frame period: 3·REFRESH_DIV cycles; first frame_done occurs 3·REFRESH_DIV cycles after reset deassertion.
- bcd_valid during reset is ignored.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - Hundreds digit shows blank (00) if active[11:8]==0.
  - Tens digit shows blank if active[11:8]==0 and active[7:4]==0.
  - Ones digit is always shown.
  - Nibbles ≥A are never treated as zero.
  - Blanked slots still enable dig_sel (pattern off only), so slot timing is unchanged.
- When undefined: all three digits are always displayed, including leading zeros.

Test Plan:
- Params REFRESH_DIV=8, BLANK_CYCLES=2, active-low polarities. Reset for 3 cycles, then release:
  - seg_out=FF and dig_sel=111 during reset.
  - First SHOW cycle enables dig_sel=110 with seg_out=C0 (digit 0).
  - frame_done first pulses 24 cycles after release.
- bcd_valid with bcd_in=12'h255 mid-frame:
  - Display is unchanged until the wrap.
  - Next frame shows ones=~6D, tens=~6D, hundreds=~5B.
  - Each digit has 6 SHOW cycles and 2 all-off cycles.
- Two strobes, 12'h123 then 12'h045, within one frame → only 045 is committed; 123 never appears on any digit.
- bcd_valid with bcd_in=12'h007 on the exact wrap cycle → committed that wrap; the following frame shows 0,0,7 with no extra frame delay.
- bcd_in=12'h0A5 → tens slot shows ~40 (dash).
- With SEG_LEADING_ZERO_BLANK_EN defined, bcd_in=12'h005 → hundreds and tens show FF with their dig_sel still active, ones shows ~6D.
- Reset asserted mid-SHOW of digit 1 → next cycle outputs off; the scan restarts at digit 0 with active=0.
